// File: rtl/bresenham_pkg.sv
// Shared types and widths for the Bresenham raycast stepper.
package bresenham_pkg;

  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;
  localparam int unsigned CW  = 8;
  localparam int unsigned EW  = CW + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic flip_x;
    logic flip_y;
    logic flip_identity;
  } octant_t;

  typedef logic signed [EW-1:0] err_t;

endpackage

// File: rtl/bresenham_stepper_if.sv
// Request and canonical-point bus between the segment source, the stepper and the mapper.
interface bresenham_stepper_if;
  import bresenham_pkg::*;

  logic           req_valid;
  logic           req_ready;
  logic [X_W-1:0] x0;
  logic [X_W-1:0] x1;
  logic [Y_W-1:0] y0;
  logic [Y_W-1:0] y1;
  logic           pt_valid;
  logic           pt_ready;
  logic [CW-1:0]  pt_cx;
  logic [CW-1:0]  pt_cy;
  logic           pt_last;
  logic           flip_x;
  logic           flip_y;
  logic           flip_identity;
  logic           busy;

  modport master (
    output req_valid, x0, x1, y0, y1, pt_ready,
    input  req_ready, pt_valid, pt_cx, pt_cy, pt_last,
           flip_x, flip_y, flip_identity, busy
  );

  modport slave (
    input  req_valid, x0, x1, y0, y1, pt_ready,
    output req_ready, pt_valid, pt_cx, pt_cy, pt_last,
           flip_x, flip_y, flip_identity, busy
  );

endinterface

// File: rtl/line_octant_setup.sv
// Folds a segment into the first octant: flip flags, canonical start point and axis deltas.
module line_octant_setup
  import bresenham_pkg::*;
(
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  output octant_t        oct,
  output logic [CW-1:0]  cx0,
  output logic [CW-1:0]  cy0,
  output logic [CW-1:0]  dmaj,
  output logic [CW-1:0]  dmin
);

  localparam int unsigned DW = CW + 1;

  logic [DW-1:0] dx;
  logic [DW-1:0] dy;
  logic [CW-1:0] adx;
  logic [CW-1:0] ady;
  logic [CW-1:0] x0e;
  logic [CW-1:0] y0e;
  logic [CW-1:0] maj0;
  logic [CW-1:0] min0;
  logic          steep;

  // Ties (|dx|==|dy|) stay shallow so the diagonal keeps x as the major axis.
  always_comb begin
    x0e   = CW'(x0);
    y0e   = CW'(y0);
    dx    = DW'(x1) - DW'(x0);
    dy    = DW'(y1) - DW'(y0);
    adx   = dx[DW-1] ? CW'(-dx) : dx[CW-1:0];
    ady   = dy[DW-1] ? CW'(-dy) : dy[CW-1:0];
    steep = (ady > adx);

    oct.flip_identity = steep;
    oct.flip_x        = steep ? dy[DW-1] : dx[DW-1];
    oct.flip_y        = steep ? dx[DW-1] : dy[DW-1];

    maj0 = steep ? y0e : x0e;
    min0 = steep ? x0e : y0e;
    cx0  = oct.flip_x ? -maj0 : maj0;
    cy0  = oct.flip_y ? -min0 : min0;
    dmaj = steep ? ady : adx;
    dmin = steep ? adx : ady;
  end

endmodule

// File: rtl/bresenham_stepper.sv
// Bresenham stepper: folds a segment into octant 0 and emits one canonical point per handshake.
// Build option BRESENHAM_SKIP_ENDPOINT_EN drops the final endpoint (free-cell rays).
module bresenham_stepper
  import bresenham_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  bresenham_stepper_if.slave bus
);

  state_t         state;
  state_t         state_nxt;

  logic [X_W-1:0] x0_q;
  logic [X_W-1:0] x1_q;
  logic [Y_W-1:0] y0_q;
  logic [Y_W-1:0] y1_q;

  octant_t        s_oct;
  logic [CW-1:0]  s_cx0;
  logic [CW-1:0]  s_cy0;
  logic [CW-1:0]  s_dmaj;
  logic [CW-1:0]  s_dmin;

  octant_t        oct_q;
  logic [CW-1:0]  cx_q;
  logic [CW-1:0]  cy_q;
  logic [CW-1:0]  rem_q;
  logic [CW-1:0]  dmaj_q;
  logic [CW-1:0]  dmin_q;
  err_t           err_q;

  logic           pt_valid_q;
  logic           pt_last_q;
  logic           req_ready_q;
  logic           busy_q;

  logic           fire_c;
  logic           err_pos_c;
  logic           skip_zero_c;
  logic [CW-1:0]  rem_init_c;
  err_t           two_dmin_c;
  err_t           two_dmaj_c;
  err_t           s_two_dmin_c;

  line_octant_setup u_setup (
    .x0   (x0_q),
    .x1   (x1_q),
    .y0   (y0_q),
    .y1   (y1_q),
    .oct  (s_oct),
    .cx0  (s_cx0),
    .cy0  (s_cy0),
    .dmaj (s_dmaj),
    .dmin (s_dmin)
  );

  // Remaining count is biased so that pt_last always means "rem_q == 0".
`ifdef BRESENHAM_SKIP_ENDPOINT_EN
  assign skip_zero_c = (s_dmaj == '0);
  assign rem_init_c  = s_dmaj - CW'(1);
`else
  assign skip_zero_c = 1'b0;
  assign rem_init_c  = s_dmaj;
`endif

  assign fire_c       = pt_valid_q & bus.pt_ready;
  assign err_pos_c    = !err_q[EW-1] && (err_q != '0);
  assign two_dmin_c   = EW'({dmin_q, 1'b0});
  assign two_dmaj_c   = EW'({dmaj_q, 1'b0});
  assign s_two_dmin_c = EW'({s_dmin, 1'b0});

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = SETUP;
      SETUP:   state_nxt = skip_zero_c ? IDLE : RUN;
      RUN:     if (fire_c && pt_last_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with handshake/status outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pt_valid_q  <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pt_valid_q  <= (state_nxt == RUN);
      req_ready_q <= (state_nxt == IDLE);
      busy_q      <= (state_nxt != IDLE);
    end
  end

  // Endpoint capture, octant load and per-handshake Bresenham step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      oct_q     <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      rem_q     <= '0;
      dmaj_q    <= '0;
      dmin_q    <= '0;
      err_q     <= '0;
      pt_last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            x0_q <= bus.x0;
            x1_q <= bus.x1;
            y0_q <= bus.y0;
            y1_q <= bus.y1;
          end
        end
        SETUP: begin
          oct_q     <= s_oct;
          cx_q      <= s_cx0;
          cy_q      <= s_cy0;
          dmaj_q    <= s_dmaj;
          dmin_q    <= s_dmin;
          err_q     <= s_two_dmin_c - EW'(s_dmaj);
          rem_q     <= rem_init_c;
          pt_last_q <= (rem_init_c == '0);
        end
        RUN: begin
          if (fire_c) begin
            if (pt_last_q) begin
              pt_last_q <= 1'b0;
            end else begin
              cx_q      <= cx_q + CW'(1);
              rem_q     <= rem_q - CW'(1);
              pt_last_q <= (rem_q == CW'(1));
              if (err_pos_c) begin
                cy_q  <= cy_q + CW'(1);
                err_q <= err_q + two_dmin_c - two_dmaj_c;
              end else begin
                err_q <= err_q + two_dmin_c;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.pt_valid      = pt_valid_q;
  assign bus.pt_cx         = cx_q;
  assign bus.pt_cy         = cy_q;
  assign bus.pt_last       = pt_last_q;
  assign bus.flip_x        = oct_q.flip_x;
  assign bus.flip_y        = oct_q.flip_y;
  assign bus.flip_identity = oct_q.flip_identity;
  assign bus.busy          = busy_q;

endmodule
